// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port of mem_bus_arbiter.
// Handshake: a requester raises mem_op with adr/do/wren stable and holds them until mem_rdy is
// seen high on a rising edge; mem_rdy is a one-cycle completion pulse and di is valid only with it.
interface mem_bus_arbiter_if;
    logic        m0_mem_op;
    logic        m0_mem_rdy;
    logic [31:0] m0_adr;
    logic [31:0] m0_do;
    logic [3:0]  m0_wren;
    logic [31:0] m0_di;

    logic        m1_mem_op;
    logic        m1_mem_rdy;
    logic [31:0] m1_adr;
    logic [31:0] m1_do;
    logic [3:0]  m1_wren;
    logic [31:0] m1_di;

    logic        s_mem_op;
    logic        s_mem_rdy;
    logic [31:0] s_adr;
    logic [31:0] s_do;
    logic [3:0]  s_wren;
    logic [31:0] s_di;

    // Arbiter view: serves both requesters and drives the shared memory port.
    modport slave (
        input  m0_mem_op, m0_adr, m0_do, m0_wren,
        output m0_mem_rdy, m0_di,
        input  m1_mem_op, m1_adr, m1_do, m1_wren,
        output m1_mem_rdy, m1_di,
        output s_mem_op, s_adr, s_do, s_wren,
        input  s_mem_rdy, s_di
    );

    // Environment view: the requesters and the memory behind the arbiter.
    modport master (
        output m0_mem_op, m0_adr, m0_do, m0_wren,
        input  m0_mem_rdy, m0_di,
        output m1_mem_op, m1_adr, m1_do, m1_wren,
        input  m1_mem_rdy, m1_di,
        input  s_mem_op, s_adr, s_do, s_wren,
        output s_mem_rdy, s_di
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a picorv32-native memory port, with whole-transaction
// grants and a watchdog that force-completes stalled transactions and flags a sticky error.
module mem_bus_arbiter #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_arbiter_if.slave  bus,
    input  logic              err_clr,
    output logic              grant,
    output logic              busy,
    output logic              timeout_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam int          CW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TO_EN      = (TIMEOUT != 0);
    localparam logic [CW-1:0] LAST_CYCLE = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [0:0]    state;
    logic          last;
    logic [CW-1:0] cnt;

    logic gnt_op;
    logic done_ok;
    logic done_to;
    logic done;

    // cnt holds the number of BUSY cycles already spent, so cnt == TIMEOUT-1 marks the last one.
    assign busy    = (state == BUSY);
    assign gnt_op  = grant ? bus.m1_mem_op : bus.m0_mem_op;
    assign done_ok = busy && gnt_op && bus.s_mem_rdy;
    assign done_to = TO_EN && busy && gnt_op && !bus.s_mem_rdy && (cnt == LAST_CYCLE);
    assign done    = done_ok || done_to;

    assign bus.s_mem_op   = busy;
    assign bus.s_adr      = busy ? (grant ? bus.m1_adr  : bus.m0_adr)  : '0;
    assign bus.s_do       = busy ? (grant ? bus.m1_do   : bus.m0_do)   : '0;
    assign bus.s_wren     = busy ? (grant ? bus.m1_wren : bus.m0_wren) : '0;

    assign bus.m0_mem_rdy = done && !grant;
    assign bus.m1_mem_rdy = done && grant;
    assign bus.m0_di      = done_to ? ERR_DATA : bus.s_di;
    assign bus.m1_di      = done_to ? ERR_DATA : bus.s_di;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last        <= 1'b1;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m0_mem_op || bus.m1_mem_op) begin
                        // On a conflict the master not served last wins.
                        grant <= (bus.m0_mem_op && bus.m1_mem_op) ? ~last : bus.m1_mem_op;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!gnt_op) begin
                        state <= IDLE;
                    end else if (done) begin
                        last  <= grant;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (done_to) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter with TIMEOUT = 4 against a
// transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int TO = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset;
  logic err_clr;
  logic grant;
  logic busy;
  logic timeout_err;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR_DATA)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .err_clr(err_clr),
    .grant(grant),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_of(input int m);
    return (m != 0) ? bus.m1_mem_rdy : bus.m0_mem_rdy;
  endfunction

  function automatic logic [31:0] di_of(input int m);
    return (m != 0) ? bus.m1_di : bus.m0_di;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int m, input logic op, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] wr);
    if (m == 0) begin
      bus.m0_mem_op = op; bus.m0_adr = adr; bus.m0_do = dat; bus.m0_wren = wr;
    end else begin
      bus.m1_mem_op = op; bus.m1_adr = adr; bus.m1_do = dat; bus.m1_wren = wr;
    end
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    bus.s_mem_rdy = 1'b0;
    bus.s_di      = 32'h0;
    err_clr       = 1'b0;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    idle_all();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".s_mem_op"}, bus.s_mem_op, 1'b0);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".m0_rdy"}, bus.m0_mem_rdy, 1'b0);
    check({tag, ".m1_rdy"}, bus.m1_mem_rdy, 1'b0);
  endtask

  task automatic check_busy(input string tag, input int owner, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] wr);
    check({tag, ".busy"}, busy, 1'b1);
    check({tag, ".s_mem_op"}, bus.s_mem_op, 1'b1);
    check({tag, ".grant"}, grant, owner);
    check({tag, ".s_adr"}, bus.s_adr, adr);
    check({tag, ".s_do"}, bus.s_do, dat);
    check({tag, ".s_wren"}, bus.s_wren, wr);
  endtask

  task automatic check_rdy(input string tag, input int owner, input logic exp_rdy,
                           input logic [31:0] exp_di);
    check({tag, ".rdy"}, rdy_of(owner), exp_rdy);
    check({tag, ".other_rdy"}, rdy_of(1 - owner), 1'b0);
    if (exp_rdy) check({tag, ".di"}, di_of(owner), exp_di);
  endtask

  // ---------------- reference model state ----------------
  bit          pend[2];
  logic [31:0] padr[2];
  logic [31:0] pdo[2];
  logic [3:0]  pwr[2];
  int          model_last;
  logic        model_err;
  int          owner;
  int          d;
  int          fin;
  logic [31:0] sdi;

  initial begin
    reset = 1'b1;
    idle_all();
    step();
    step();
    #1;
    check("rst.s_mem_op", bus.s_mem_op, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.grant", grant, 1'b0);
    check("rst.timeout_err", timeout_err, 1'b0);
    check("rst.s_adr", bus.s_adr, 32'h0);
    check("rst.s_wren", bus.s_wren, 4'h0);
    check("rst.m0_rdy", bus.m0_mem_rdy, 1'b0);
    reset = 1'b0;

    // m0 read, slave ready one cycle after s_mem_op
    step(); set_req(0, 1'b1, 32'h20000, 32'h0, 4'h0); #1 check_idle("rd.c0");
    step(); #1 check_busy("rd.c1", 0, 32'h20000, 32'h0, 4'h0); check_rdy("rd.c1", 0, 1'b0, 32'h0);
    step(); bus.s_mem_rdy = 1'b1; bus.s_di = 32'h12345678;
    #1 check_rdy("rd.c2", 0, 1'b1, 32'h12345678);
    step(); bus.s_mem_rdy = 1'b0; set_req(0, 1'b0, 32'h0, 32'h0, 4'h0); #1 check_idle("rd.c3");

    // both masters request continuously, slave always ready: strict alternation from m0
    do_reset();
    set_req(0, 1'b1, 32'h0000_1000, 32'h0, 4'h0);
    set_req(1, 1'b1, 32'h0000_2000, 32'h0, 4'h0);
    bus.s_mem_rdy = 1'b1;
    #1 check_idle("rr.start");
    for (int i = 0; i < 4; i++) begin
      step();
      bus.s_di = 32'hA000_0000 + i;
      #1 check_busy("rr.busy", i % 2, (i % 2) ? 32'h0000_2000 : 32'h0000_1000, 32'h0, 4'h0);
      check_rdy("rr.done", i % 2, 1'b1, 32'hA000_0000 + i);
      step();
      if (i == 3) begin
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.s_mem_rdy = 1'b0;
      end
      #1 check_idle("rr.gap");
    end

    // m1 write while m0 has junk on its idle inputs
    step();
    set_req(1, 1'b1, 32'h0000FFFC, 32'hCAFEF00D, 4'b0011);
    set_req(0, 1'b0, 32'hFFFF_FFFF, 32'h1111_1111, 4'hF);
    #1 check_idle("wr.c0");
    for (int k = 1; k <= 3; k++) begin
      step(); bus.s_mem_rdy = (k == 3); bus.s_di = 32'h0;
      #1 check_busy("wr.busy", 1, 32'h0000FFFC, 32'hCAFEF00D, 4'b0011);
      check_rdy("wr.rdy", 1, k == 3, 32'h0);
    end
    step(); bus.s_mem_rdy = 1'b0; idle_all(); #1 check_idle("wr.end");

    // timeout: slave never ready
    step(); set_req(0, 1'b1, 32'h100, 32'h0, 4'h0); #1;
    for (int k = 1; k <= TO; k++) begin
      step();
      #1 check_busy("to.busy", 0, 32'h100, 32'h0, 4'h0);
      check_rdy("to.rdy", 0, k == TO, ERR_DATA);
      check("to.err_pending", timeout_err, 1'b0);
    end
    step(); set_req(0, 1'b0, 32'h0, 32'h0, 4'h0); err_clr = 1'b1;
    #1 check_idle("to.after"); check("to.err_set", timeout_err, 1'b1);
    step(); err_clr = 1'b0; set_req(0, 1'b1, 32'h104, 32'h0, 4'h0);
    #1 check("to.err_cleared", timeout_err, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      step(); err_clr = (k == TO);
      #1 check_rdy("to2.rdy", 0, k == TO, ERR_DATA);
    end
    step(); err_clr = 1'b0; set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 check("to2.set_wins", timeout_err, 1'b1);

    // slave ready exactly in the last allowed BUSY cycle: normal completion
    step(); err_clr = 1'b1; set_req(0, 1'b1, 32'h200, 32'h0, 4'h0); #1 check_idle("edge.c0");
    for (int k = 1; k <= TO; k++) begin
      step(); err_clr = 1'b0; bus.s_mem_rdy = (k == TO); bus.s_di = 32'h5A5A1234;
      #1 check_rdy("edge.rdy", 0, k == TO, 32'h5A5A1234);
      check("edge.err", timeout_err, 1'b0);
    end
    step(); bus.s_mem_rdy = 1'b0; set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1 check_idle("edge.end"); check("edge.err_after", timeout_err, 1'b0);

    // reset in BUSY cycle 2 abandons the transaction; first conflict afterwards goes to m0
    step(); set_req(1, 1'b1, 32'h300, 32'h0, 4'h0); #1;
    step(); #1 check_busy("mid.c1", 1, 32'h300, 32'h0, 4'h0);
    step(); reset = 1'b1; #1 check_rdy("mid.c2", 1, 1'b0, 32'h0);
    step(); reset = 1'b0; set_req(0, 1'b1, 32'h400, 32'h0, 4'h0);
    #1 check_idle("mid.after"); check("mid.grant", grant, 1'b0);
    step(); bus.s_mem_rdy = 1'b1; bus.s_di = 32'h0000_0400;
    #1 check_busy("mid.conflict", 0, 32'h400, 32'h0, 4'h0);
    check_rdy("mid.conflict", 0, 1'b1, 32'h0000_0400);
    step(); bus.s_mem_rdy = 1'b0; set_req(0, 1'b0, 32'h0, 32'h0, 4'h0); #1 check_idle("mid.gap");
    step(); bus.s_mem_rdy = 1'b1; bus.s_di = 32'h0000_0300;
    #1 check_busy("mid.m1", 1, 32'h300, 32'h0, 4'h0); check_rdy("mid.m1", 1, 1'b1, 32'h0000_0300);
    step(); idle_all(); #1 check_idle("mid.end");

    // randomized traffic against the transaction-level model
    model_last = 1;
    model_err  = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int t = 0; t < 200; t++) begin
      step();
      bus.s_mem_rdy = 1'b0;
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && ($urandom_range(0, 1) == 1)) begin
          pend[m] = 1'b1;
          padr[m] = $urandom;
          pdo[m]  = $urandom;
          pwr[m]  = 4'($urandom_range(0, 15));
        end
      end
      if (!pend[0] && !pend[1]) begin
        owner = $urandom_range(0, 1);
        pend[owner] = 1'b1;
        padr[owner] = $urandom;
        pdo[owner]  = $urandom;
        pwr[owner]  = 4'($urandom_range(0, 15));
      end
      for (int m = 0; m < 2; m++) set_req(m, pend[m], padr[m], pdo[m], pwr[m]);
      err_clr = ($urandom_range(0, 3) == 0);
      #1 check_idle("rnd.idle");
      check("rnd.err_idle", timeout_err, model_err);
      if (err_clr) model_err = 1'b0;

      owner = (pend[0] && pend[1]) ? 1 - model_last : (pend[1] ? 1 : 0);
      d     = $urandom_range(1, TO + 2);
      fin   = (d <= TO) ? d : TO;
      sdi   = $urandom;
      exp_q.push_back((d <= TO) ? sdi : ERR_DATA);

      for (int k = 1; k <= fin; k++) begin
        step();
        err_clr = 1'b0;
        bus.s_mem_rdy = (k == d);
        bus.s_di = (k == d) ? sdi : $urandom;
        #1 check_busy("rnd.busy", owner, padr[owner], pdo[owner], pwr[owner]);
        check("rnd.err_busy", timeout_err, model_err);
        if (k == fin) check_rdy("rnd.done", owner, 1'b1, exp_q.pop_front());
        else          check_rdy("rnd.wait", owner, 1'b0, 32'h0);
      end
      model_last  = owner;
      if (d > TO) model_err = 1'b1;
      pend[owner] = 1'b0;
    end

    step();
    idle_all();
    #1 check_idle("final");
    check("final.err", timeout_err, model_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
